cpld4_row_collector: RTL and testbench
======================================

# cpld4_row_collector

Downstream stage of the CPLD3 cell. It consumes CPLD3's per-column result stream (5-bit data, 4-bit select tag, last-row flag) and reassembles the out-of-order column words of each row in a capture buffer. Each completed row is handed to a ready/valid output port, one word per cycle in column order 0..COLS-1, with frame-end marking. Row assembly and output are double-buffered, so a new row can fill while the previous one drains.

## Interface
- COLS, 8: columns per row; legal 2..8.
- WIDTH, 5: data word width.

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- left_in  input  WIDTH  column word from CPLD3 right_out2.
- sel_in  input  4  from CPLD3 sel_out2; [3] = write strobe, [2:0] = column index.
- last_row  input  1  from CPLD3 last_row; marks the current row as the frame's final row.
- out_data  output  WIDTH  current output word.
- out_col  output  3  column index of out_data.
- out_valid  output  1  out_data/out_col/out_last valid.
- out_ready  input  1  downstream accepts the word.
- out_last  output  1  high only on the column COLS-1 word of a last-row row.
- row_count  output  8  rows fully emitted since reset; wraps 255->0.
- overflow  output  1  sticky; a write was dropped because the capture buffer was full.
- col_err  output  1  sticky; a duplicate-column write or column index >= COLS was seen.

## Operation
- Capture side: COLS x WIDTH buffer, COLS-bit written mask, row_full flag, row_last flag.
- A write is accepted when sel_in[3]=1, column < COLS, mask bit clear, and row_full=0. It stores left_in, sets the mask bit, and ORs last_row into row_last.
- Duplicate column, mask bit already set: write ignored, first value kept, col_err set.
- Column >= COLS: write ignored, col_err set.
- Write while row_full=1 and no transfer at that edge: dropped, overflow set.
- When an accepted write makes the mask all-ones, row_full is set at that edge.
- Output FSM, two states:
  - IDLE: out_valid=0. If row_full, the transfer copies the buffer and row_last into the output register, clears the mask, row_full and row_last, sets rd_col=0, and moves to SEND.
  - SEND: out_valid=1, out_data=word[rd_col], out_col=rd_col.
    - On handshake (out_valid & out_ready): rd_col increments.
    - At rd_col=COLS-1 the handshake also increments row_count. The FSM then transfers again if row_full (stays SEND, rd_col=0, back-to-back); otherwise it goes to IDLE.
- Transfer edge with a simultaneous write: the mask is cleared first and the write lands in the fresh row. It is accepted, with no overflow. It sets row_full if COLS=... (cannot complete a row alone).
- out_last = SEND & rd_col==COLS-1 & latched row_last.
- Sticky flags clear only on reset.

## Timing
- Reset (rst=0, asynchronous): state IDLE, mask 0, row_full 0, row_last 0, rd_col 0. All outputs 0: out_data, out_col, out_valid, out_last, row_count, overflow, col_err.
- Reset mid-row or mid-SEND discards all data. No partial output after release.
- Latency: the completing write is sampled at edge N, row_full is visible after N, and the transfer happens at N+1. out_valid is high with column 0 after N+1, so write-to-first-word is 2 cycles.
- Output words are held stable while out_valid=1 and out_ready=0.
- Full-speed drain: COLS cycles per row with out_ready=1 and no bubble between back-to-back rows.
- Capture is blocked from row_full set until the transfer edge. Upstream must not write into that window.
- row_count wrap: 255 + 1 = 0, with no flag.

## Test plan
- COLS=8, writes to columns 7,3,0,5,1,6,2,4 with data=col+10, out_ready=1:
  - out_valid rises 2 cycles after the column-4 write.
  - Words 10..17 come out on columns 0..7 on consecutive cycles.
  - row_count=1, out_last=0.
- Same row with last_row=1 on one write only: out_last=1 exactly on the col 7 word, with data 17.
- out_ready toggled 1,0,0,1… during SEND: data/col hold while not ready, all 8 words are delivered once, and there is no duplication.
- Two rows written back-to-back (8 cycles each) with out_ready=1:
  - Row 2 begins the cycle after row 1's col 7 handshake.
  - row_count=2, overflow=0.
- Duplicate write to column 2 (values 5 then 9), then column index 7 with COLS=6: col_err=1 and column 2 outputs 5.
- Complete row with out_ready=0, a second full row filled, then a 9th write: overflow=1. After reset mid-SEND, all outputs are 0 and a following clean row emits correctly.

Source files
------------

// File: rtl/cpld4_row_collector.sv
// cpld4_row_collector: reassembles CPLD3 column words into rows
// and drains each row in column order on a ready/valid port.
module cpld4_row_collector #(
  parameter int COLS  = 8,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] left_in,
  input  logic [3:0]       sel_in,
  input  logic             last_row,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_col,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [7:0]       row_count,
  output logic             overflow,
  output logic             col_err
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  localparam logic [2:0] LAST_COL = 3'(COLS - 1);
  localparam logic [3:0] NCOLS    = 4'(COLS);

  logic [COLS-1:0][WIDTH-1:0] cap_q, cap_d;
  logic [COLS-1:0][WIDTH-1:0] word_q, word_d;
  logic [COLS-1:0]            mask_q, mask_d;
  logic                       row_full_q, row_full_d;
  logic                       row_last_q, row_last_d;
  logic                       last_q, last_d;
  state_t                     state_q, state_d;
  logic [2:0]                 rd_col_q, rd_col_d;
  logic [7:0]                 row_count_q, row_count_d;
  logic                       overflow_q, overflow_d;
  logic                       col_err_q, col_err_d;

  logic       wr_en;
  logic [2:0] wr_col;
  logic       col_ok;
  logic       hs;
  logic       row_done;
  logic       xfer;
  logic [COLS-1:0] mask_base;
  logic       full_base;
  logic       last_base;
  logic       bad_col;
  logic       drop;
  logic       dup;
  logic       accept;

  assign wr_en    = sel_in[3];
  assign wr_col   = sel_in[2:0];
  assign col_ok   = {1'b0, wr_col} < NCOLS;
  assign hs       = (state_q == SEND) & out_ready;
  assign row_done = hs & (rd_col_q == LAST_COL);
  assign xfer     = row_full_q
                  & ((state_q == IDLE) | row_done);

  // A transfer empties the capture row before this edge's write lands.
  assign mask_base = xfer ? '0 : mask_q;
  assign full_base = xfer ? 1'b0 : row_full_q;
  assign last_base = xfer ? 1'b0 : row_last_q;

  assign bad_col = wr_en & ~col_ok;
  assign drop    = wr_en & col_ok & full_base;
  assign dup     = wr_en & col_ok & ~full_base
                 & mask_base[wr_col];
  assign accept  = wr_en & col_ok & ~full_base
                 & ~mask_base[wr_col];

  // Capture side: store accepted words, track the mask and error flags.
  always_comb begin
    cap_d      = cap_q;
    mask_d     = mask_base;
    row_full_d = full_base;
    row_last_d = last_base;
    overflow_d = overflow_q;
    col_err_d  = col_err_q;
    unique case (1'b1)
      bad_col: col_err_d = 1'b1;
      drop:    overflow_d = 1'b1;
      dup:     col_err_d = 1'b1;
      accept: begin
        cap_d[wr_col]  = left_in;
        mask_d[wr_col] = 1'b1;
        row_last_d     = last_base | last_row;
        row_full_d     = &mask_d;
      end
      default: ;
    endcase
  end

  // Output FSM: latch a full row, then drain it one word per handshake.
  always_comb begin
    state_d     = state_q;
    rd_col_d    = rd_col_q;
    word_d      = word_q;
    last_d      = last_q;
    row_count_d = row_count_q;
    unique case (state_q)
      IDLE: ;
      SEND: begin
        if (hs) begin
          if (rd_col_q == LAST_COL) begin
            row_count_d = row_count_q + 8'd1;
            rd_col_d    = 3'd0;
            state_d     = IDLE;
          end else begin
            rd_col_d = rd_col_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (xfer) begin
      word_d   = cap_q;
      last_d   = row_last_q;
      rd_col_d = 3'd0;
      state_d  = SEND;
    end
  end

  // State registers; reset discards any partial or pending row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_q       <= '0;
      word_q      <= '0;
      mask_q      <= '0;
      row_full_q  <= 1'b0;
      row_last_q  <= 1'b0;
      last_q      <= 1'b0;
      state_q     <= IDLE;
      rd_col_q    <= 3'd0;
      row_count_q <= 8'd0;
      overflow_q  <= 1'b0;
      col_err_q   <= 1'b0;
    end else begin
      cap_q       <= cap_d;
      word_q      <= word_d;
      mask_q      <= mask_d;
      row_full_q  <= row_full_d;
      row_last_q  <= row_last_d;
      last_q      <= last_d;
      state_q     <= state_d;
      rd_col_q    <= rd_col_d;
      row_count_q <= row_count_d;
      overflow_q  <= overflow_d;
      col_err_q   <= col_err_d;
    end
  end

  assign out_valid = (state_q == SEND);
  assign out_data  = out_valid ? word_q[rd_col_q] : '0;
  assign out_col   = rd_col_q;
  assign out_last  = out_valid & (rd_col_q == LAST_COL)
                   & last_q;
  assign row_count = row_count_q;
  assign overflow  = overflow_q;
  assign col_err   = col_err_q;

endmodule

// File: tb/tb_cpld4_row_collector.sv
// tb_cpld4_row_collector: directed scoreboard bench for the
// row collector, with an 8-column and a 6-column instance.
module tb_cpld4_row_collector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [4:0] d8, d6;
  logic [3:0] sel8, sel6;
  logic       lr8, lr6, rdy8, rdy6;
  logic [4:0] o8_data, o6_data;
  logic [2:0] o8_col, o6_col;
  logic       o8_valid, o6_valid, o8_last, o6_last;
  logic [7:0] o8_rc, o6_rc;
  logic       o8_ovf, o6_ovf, o8_err, o6_err;

  cpld4_row_collector #(.COLS(8), .WIDTH(5)) u8 (
    .clk(clk), .rst(rst), .left_in(d8), .sel_in(sel8),
    .last_row(lr8), .out_data(o8_data), .out_col(o8_col),
    .out_valid(o8_valid), .out_ready(rdy8),
    .out_last(o8_last), .row_count(o8_rc),
    .overflow(o8_ovf), .col_err(o8_err)
  );

  cpld4_row_collector #(.COLS(6), .WIDTH(5)) u6 (
    .clk(clk), .rst(rst), .left_in(d6), .sel_in(sel6),
    .last_row(lr6), .out_data(o6_data), .out_col(o6_col),
    .out_valid(o6_valid), .out_ready(rdy6),
    .out_last(o6_last), .row_count(o6_rc),
    .overflow(o6_ovf), .col_err(o6_err)
  );

  typedef struct packed {
    logic [4:0] d;
    logic [2:0] c;
    logic       l;
  } exp_t;

  exp_t q8[$];
  exp_t q6[$];
  int n_chk = 0;
  int n_fail = 0;
  int ord[8] = '{7, 3, 0, 5, 1, 6, 2, 4};
  bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor for the 8-column instance.
  logic       st8;
  logic [4:0] pd8;
  logic [2:0] pc8;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      st8 = 1'b0;
    end else begin
      if (st8) begin
        chk("hold8 valid", 32'(o8_valid), 32'd1);
        chk("hold8 data", 32'(o8_data), 32'(pd8));
        chk("hold8 col", 32'(o8_col), 32'(pc8));
      end
      if (o8_valid && rdy8) begin
        if (q8.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL word8 unexpected: got col %0d data %0d",
                   o8_col, o8_data);
        end else begin
          e = q8.pop_front();
          chk("word8 data", 32'(o8_data), 32'(e.d));
          chk("word8 col", 32'(o8_col), 32'(e.c));
          chk("word8 last", 32'(o8_last), 32'(e.l));
        end
      end
      st8 = o8_valid && !rdy8;
      pd8 = o8_data;
      pc8 = o8_col;
    end
  end

  // Monitor for the 6-column instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst && o6_valid && rdy6) begin
      if (q6.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL word6 unexpected: got col %0d data %0d",
                 o6_col, o6_data);
      end else begin
        e = q6.pop_front();
        chk("word6 data", 32'(o6_data), 32'(e.d));
        chk("word6 col", 32'(o6_col), 32'(e.c));
        chk("word6 last", 32'(o6_last), 32'(e.l));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr8(input int c, input int d, input bit l);
    sel8 = {1'b1, 3'(c)};
    d8   = 5'(d);
    lr8  = l;
    cyc(1);
    sel8 = 4'd0;
    d8   = 5'd0;
    lr8  = 1'b0;
  endtask

  task automatic wr6(input int c, input int d);
    sel6 = {1'b1, 3'(c)};
    d6   = 5'(d);
    cyc(1);
    sel6 = 4'd0;
    d6   = 5'd0;
  endtask

  task automatic row8(input int base, input bit push,
                      input bit last, input int lcol);
    if (push) begin
      for (int c = 0; c < 8; c++)
        q8.push_back(exp_t'{d: 5'(base + c), c: 3'(c),
                            l: (last && c == 7)});
    end
    for (int i = 0; i < 8; i++)
      wr8(ord[i], base + ord[i], last && ord[i] == lcol);
  endtask

  task automatic chk_reset8(input string tag);
    chk({tag, " valid"}, 32'(o8_valid), 32'd0);
    chk({tag, " data"}, 32'(o8_data), 32'd0);
    chk({tag, " col"}, 32'(o8_col), 32'd0);
    chk({tag, " last"}, 32'(o8_last), 32'd0);
    chk({tag, " row_count"}, 32'(o8_rc), 32'd0);
    chk({tag, " overflow"}, 32'(o8_ovf), 32'd0);
    chk({tag, " col_err"}, 32'(o8_err), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc(1);
    q8.delete();
    q6.delete();
    rst = 1'b1;
    cyc(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bub;
    int k;
    rst  = 1'b0;
    d8   = 5'd0;
    sel8 = 4'd0;
    lr8  = 1'b0;
    rdy8 = 1'b1;
    d6   = 5'd0;
    sel6 = 4'd0;
    lr6  = 1'b0;
    rdy6 = 1'b1;
    cyc(2);
    chk_reset8("reset");
    chk("reset6 valid", 32'(o6_valid), 32'd0);
    rst = 1'b1;
    cyc(1);

    // Out-of-order row, full-speed drain, 2-cycle latency.
    row8(10, 1'b1, 1'b0, 0);
    @(negedge clk);
    chk("latency early valid", 32'(o8_valid), 32'd0);
    @(negedge clk);
    chk("latency valid", 32'(o8_valid), 32'd1);
    chk("latency first col", 32'(o8_col), 32'd0);
    repeat (8) @(negedge clk);
    chk("drain8 done valid", 32'(o8_valid), 32'd0);
    chk("row1 row_count", 32'(o8_rc), 32'd1);
    chk("row1 queue", 32'(q8.size()), 32'd0);
    @(posedge clk);
    #1;

    // last_row flagged on a single middle write.
    row8(10, 1'b1, 1'b1, 3);
    cyc(14);
    chk("row2 row_count", 32'(o8_rc), 32'd2);
    chk("row2 queue", 32'(q8.size()), 32'd0);

    // Backpressure pattern during SEND.
    rdy8 = 1'b0;
    row8(20, 1'b1, 1'b0, 0);
    for (int i = 0; i < 40; i++) begin
      rdy8 = pat[i % 4];
      cyc(1);
    end
    rdy8 = 1'b1;
    cyc(4);
    chk("bp row_count", 32'(o8_rc), 32'd3);
    chk("bp queue", 32'(q8.size()), 32'd0);

    // Back-to-back rows with no bubble.
    do_reset();
    bub = 0;
    fork
      begin
        row8(0, 1'b1, 1'b0, 0);
        row8(8, 1'b1, 1'b0, 0);
      end
      begin
        k = 0;
        while (!o8_valid && k < 40) begin
          @(negedge clk);
          k++;
        end
        chk("b2b valid timeout", 32'(o8_valid), 32'd1);
        repeat (16) begin
          if (!o8_valid) bub++;
          @(negedge clk);
        end
      end
    join
    cyc(4);
    chk("b2b bubbles", 32'(bub), 32'd0);
    chk("b2b row_count", 32'(o8_rc), 32'd2);
    chk("b2b overflow", 32'(o8_ovf), 32'd0);
    chk("b2b queue", 32'(q8.size()), 32'd0);

    // Duplicate and out-of-range columns on the 6-column unit.
    q6.push_back(exp_t'{d: 5'd1, c: 3'd0, l: 1'b0});
    q6.push_back(exp_t'{d: 5'd2, c: 3'd1, l: 1'b0});
    q6.push_back(exp_t'{d: 5'd5, c: 3'd2, l: 1'b0});
    q6.push_back(exp_t'{d: 5'd4, c: 3'd3, l: 1'b0});
    q6.push_back(exp_t'{d: 5'd6, c: 3'd4, l: 1'b0});
    q6.push_back(exp_t'{d: 5'd7, c: 3'd5, l: 1'b0});
    wr6(2, 5);
    chk("c6 no err yet", 32'(o6_err), 32'd0);
    wr6(2, 9);
    chk("c6 dup col_err", 32'(o6_err), 32'd1);
    wr6(7, 3);
    wr6(0, 1);
    wr6(1, 2);
    wr6(3, 4);
    wr6(4, 6);
    wr6(5, 7);
    cyc(10);
    chk("c6 row_count", 32'(o6_rc), 32'd1);
    chk("c6 overflow", 32'(o6_ovf), 32'd0);
    chk("c6 queue", 32'(q6.size()), 32'd0);

    // Overflow while stalled, then reset mid-SEND.
    do_reset();
    rdy8 = 1'b0;
    row8(0, 1'b0, 1'b0, 0);
    row8(8, 1'b0, 1'b0, 0);
    chk("ovf before 9th", 32'(o8_ovf), 32'd0);
    wr8(0, 3, 1'b0);
    chk("ovf set", 32'(o8_ovf), 32'd1);
    chk("ovf no col_err", 32'(o8_err), 32'd0);
    chk("ovf stalled valid", 32'(o8_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk_reset8("async reset");
    cyc(1);
    rst = 1'b1;
    rdy8 = 1'b1;
    cyc(1);
    chk("post reset valid", 32'(o8_valid), 32'd0);
    row8(24, 1'b1, 1'b0, 0);
    cyc(12);
    chk("post reset row_count", 32'(o8_rc), 32'd1);
    chk("post reset queue", 32'(q8.size()), 32'd0);
    chk("post reset overflow", 32'(o8_ovf), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
